// File: rtl/sq_wave_mixer_pkg.sv
// Shared encodings for the square-wave mixer: adjust mode, button bit positions,
// and the offset-binary midpoint helper.
package sq_wave_mixer_pkg;

  typedef enum logic {
    MODE_LINEAR = 1'b0,
    MODE_EXP    = 1'b1
  } mode_e;

  localparam int BTN_DEC  = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_SEL  = 3;

  function automatic int mid_code(input int code_w);
    return 1 << (code_w - 1);
  endfunction

endpackage

// File: rtl/sq_wave_channel.sv
// One square-wave channel: half-period register with saturating adjust, phase counter and level.
// Level/hp update on the edge where adv_i/dec_i/inc_i are high; no backpressure.
module sq_wave_channel
  import sq_wave_mixer_pkg::*;
#(
  parameter int PERIOD_W   = 12,
  parameter int HP_DEFAULT = 139,
  parameter int HP_MIN     = 6,
  parameter int HP_MAX     = 3051,
  parameter int LIN_STEP   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv_i,
  input  logic                dec_i,
  input  logic                inc_i,
  input  mode_e               mode_i,
  output logic                level_o,
  output logic [PERIOD_W-1:0] hp_o
);

  // Two guard bits: one for the doubled value, one for sign on linear underflow.
  localparam int EXT_W = PERIOD_W + 2;
  localparam logic signed [EXT_W-1:0] LIN_S = EXT_W'(LIN_STEP);
  localparam logic signed [EXT_W-1:0] MIN_S = EXT_W'(HP_MIN);
  localparam logic signed [EXT_W-1:0] MAX_S = EXT_W'(HP_MAX);
  localparam logic [PERIOD_W-1:0]     ONE   = PERIOD_W'(1);

  logic [PERIOD_W-1:0]     hp_q, hp_d;
  logic [PERIOD_W-1:0]     cnt_q, cnt_d;
  logic                    level_q, level_d;
  logic signed [EXT_W-1:0] hp_ext;
  logic signed [EXT_W-1:0] adj;

  assign hp_ext = $signed({2'b00, hp_q});

  always_comb begin
    adj  = hp_ext;
    hp_d = hp_q;
    if (dec_i && !inc_i) begin
      adj = (mode_i == MODE_EXP) ? (hp_ext >>> 1) : (hp_ext - LIN_S);
    end else if (inc_i && !dec_i) begin
      adj = (mode_i == MODE_EXP) ? (hp_ext <<< 1) : (hp_ext + LIN_S);
    end
    if (dec_i ^ inc_i) begin
      if (adj < MIN_S) begin
        hp_d = PERIOD_W'(HP_MIN);
      end else if (adj > MAX_S) begin
        hp_d = PERIOD_W'(HP_MAX);
      end else begin
        hp_d = adj[PERIOD_W-1:0];
      end
    end
  end

  // >= rather than == so a freshly shortened period toggles at once instead of wrapping.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (adv_i) begin
      if (cnt_q >= hp_q - ONE) begin
        cnt_d   = '0;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hp_q    <= PERIOD_W'(HP_DEFAULT);
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign hp_o    = hp_q;

endmodule

// File: rtl/sq_wave_mixer.sv
// NUM_CH square-wave channels mixed into a clamped offset-binary code, with button-driven period control.
// code updates one cycle after a next_sample pulse and holds otherwise; no backpressure.
module sq_wave_mixer
  import sq_wave_mixer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CODE_W     = 10,
  parameter int PERIOD_W   = 12,
  parameter int CH_AMP     = 100,
  parameter int HP_DEFAULT = 139,
  parameter int HP_MIN     = 6,
  parameter int HP_MAX     = 3051,
  parameter int LIN_STEP   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                next_sample,
  input  logic [3:0]          buttons,
  input  logic [NUM_CH-1:0]   ch_en,
  output logic [CODE_W-1:0]   code,
  output logic [3:0]          leds,
  output logic [PERIOD_W-1:0] hp_sel
);

  localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = CODE_W + 4;
  localparam logic signed [SUM_W-1:0] MID_S = SUM_W'(mid_code(CODE_W));
  localparam logic signed [SUM_W-1:0] AMP_S = SUM_W'(CH_AMP);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((1 << CODE_W) - 1);

  logic [SEL_W-1:0]    sel_q, sel_d;
  mode_e               mode_q, mode_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [NUM_CH-1:0]   level_w;
  logic [PERIOD_W-1:0] hp_w [NUM_CH];
  logic signed [SUM_W-1:0] sum;
  logic [2:0]          sel_ext;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sq_wave_channel #(
      .PERIOD_W  (PERIOD_W),
      .HP_DEFAULT(HP_DEFAULT),
      .HP_MIN    (HP_MIN),
      .HP_MAX    (HP_MAX),
      .LIN_STEP  (LIN_STEP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (next_sample),
      .dec_i  (buttons[BTN_DEC] && (sel_q == SEL_W'(i))),
      .inc_i  (buttons[BTN_INC] && (sel_q == SEL_W'(i))),
      .mode_i (mode_q),
      .level_o(level_w[i]),
      .hp_o   (hp_w[i])
    );
  end

  always_comb begin
    mode_d = mode_q;
    sel_d  = sel_q;
    if (buttons[BTN_MODE]) begin
      mode_d = (mode_q == MODE_LINEAR) ? MODE_EXP : MODE_LINEAR;
    end
    if (buttons[BTN_SEL]) begin
      sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
    end
  end

  // Mix uses the levels as they stand before this edge's advance.
  always_comb begin
    sum = MID_S;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en[i]) begin
        sum = sum + (level_w[i] ? AMP_S : -AMP_S);
      end
    end
    code_d = code_q;
    if (next_sample) begin
      if (sum[SUM_W-1]) begin
        code_d = '0;
      end else if (sum > MAX_S) begin
        code_d = MAX_S[CODE_W-1:0];
      end else begin
        code_d = sum[CODE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      code_q <= CODE_W'(mid_code(CODE_W));
      mode_q <= MODE_LINEAR;
      sel_q  <= '0;
    end else begin
      code_q <= code_d;
      mode_q <= mode_d;
      sel_q  <= sel_d;
    end
  end

  assign sel_ext = 3'(sel_q);
  assign code    = code_q;
  assign hp_sel  = hp_w[sel_q];
  assign leds    = {ch_en[sel_q], sel_ext[1:0], mode_q == MODE_EXP};

endmodule

// File: tb/tb_sq_wave_mixer.sv
// Randomised self-checking bench for sq_wave_mixer against a behavioural channel/mixer model.
module tb_sq_wave_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        next_sample = 1'b0;
  logic [3:0]  buttons = 4'h0;
  logic [3:0]  ch_en = 4'h0;
  logic [9:0]  code, code_big;
  logic [3:0]  leds, leds_big;
  logic [11:0] hp_sel, hp_big;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model state: level, samples spent in the current phase, half-period.
  int m_hp  [4];
  int m_run [4];
  bit m_lvl [4];
  bit m_mode;
  int m_sel;
  int m_code, m_code_big;

  always #5 clk = ~clk;

  sq_wave_mixer dut (
    .clk(clk), .rst(rst), .next_sample(next_sample), .buttons(buttons),
    .ch_en(ch_en), .code(code), .leds(leds), .hp_sel(hp_sel)
  );

  sq_wave_mixer #(.CH_AMP(200)) dut_big (
    .clk(clk), .rst(rst), .next_sample(next_sample), .buttons(buttons),
    .ch_en(ch_en), .code(code_big), .leds(leds_big), .hp_sel(hp_big)
  );

  function automatic int sat(input int v);
    if (v < 6) return 6;
    if (v > 3051) return 3051;
    return v;
  endfunction

  function automatic int mix(input logic [3:0] en, input int amp);
    int s = 512;
    for (int i = 0; i < 4; i++) if (en[i]) s += m_lvl[i] ? amp : -amp;
    if (s < 0) s = 0;
    if (s > 1023) s = 1023;
    return s;
  endfunction

  function automatic logic [3:0] m_leds();
    logic [1:0] s2 = 2'(m_sel);
    return {ch_en[m_sel], s2, m_mode};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_hp[i] = 139; m_run[i] = 0; m_lvl[i] = 1'b1;
    end
    m_mode = 1'b0; m_sel = 0; m_code = 512; m_code_big = 512;
  endtask

  task automatic m_sample();
    m_code     = mix(ch_en, 100);
    m_code_big = mix(ch_en, 200);
    for (int i = 0; i < 4; i++) begin
      m_run[i]++;
      if (m_run[i] >= m_hp[i]) begin
        m_lvl[i] = ~m_lvl[i];
        m_run[i] = 0;
      end
    end
  endtask

  task automatic m_buttons(input logic [3:0] b);
    if (b[0] ^ b[1]) begin
      if (!m_mode) m_hp[m_sel] = sat(b[0] ? m_hp[m_sel] - 10 : m_hp[m_sel] + 10);
      else         m_hp[m_sel] = sat(b[0] ? m_hp[m_sel] / 2 : m_hp[m_sel] * 2);
    end
    if (b[2]) m_mode = ~m_mode;
    if (b[3]) m_sel = (m_sel == 3) ? 0 : m_sel + 1;
  endtask

  // Called at a negedge; returns at the following negedge with the model updated.
  task automatic step(input bit ns, input logic [3:0] b);
    next_sample = ns;
    buttons     = b;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    buttons     = 4'h0;
    if (rst) begin
      if (ns) m_sample();
      m_buttons(b);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 4'h0);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    ch_en = 4'b0001;
    do_reset();
    tot_cnt++; if (code !== 10'd512) $display("FAIL reset_code: got %0d want 512", code); else pass_cnt++;
    tot_cnt++; if (code_big !== 10'd512) $display("FAIL reset_code_big: got %0d want 512", code_big); else pass_cnt++;
    tot_cnt++; if (hp_sel !== 12'd139) $display("FAIL reset_hp: got %0d want 139", hp_sel); else pass_cnt++;
    tot_cnt++; if (hp_big !== 12'd139) $display("FAIL reset_hp_big: got %0d want 139", hp_big); else pass_cnt++;
    tot_cnt++; if (leds !== 4'b1000) $display("FAIL reset_leds: got %b want 1000", leds); else pass_cnt++;
    tot_cnt++; if (leds_big !== 4'b1000) $display("FAIL reset_leds_big: got %b want 1000", leds_big); else pass_cnt++;
  endtask

  task automatic test_single_channel();
    ch_en = 4'b0001;
    do_reset();
    for (int k = 1; k <= 279; k++) begin
      step(1'b1, 4'h0);
      tot_cnt++;
      if (code !== 10'(m_code)) $display("FAIL single_ch sample %0d: got %0d want %0d", k, code, m_code);
      else pass_cnt++;
      if (k == 1 || k == 139 || k == 279) begin
        tot_cnt++;
        if (code !== 10'd612) $display("FAIL single_ch_high sample %0d: got %0d want 612", k, code); else pass_cnt++;
      end
      if (k == 140) begin
        tot_cnt++;
        if (code !== 10'd412) $display("FAIL single_ch_low sample %0d: got %0d want 412", k, code); else pass_cnt++;
      end
    end
  endtask

  task automatic test_mix();
    ch_en = 4'b1111;
    do_reset();
    step(1'b1, 4'h0);
    tot_cnt++; if (code !== 10'd912) $display("FAIL mix_all: got %0d want 912", code); else pass_cnt++;
    tot_cnt++; if (code_big !== 10'd1023) $display("FAIL mix_clamp_hi: got %0d want 1023", code_big); else pass_cnt++;
    step(1'b0, 4'h0);
    tot_cnt++; if (code !== 10'd912) $display("FAIL mix_hold: got %0d want 912", code); else pass_cnt++;
    ch_en = 4'b0000;
    step(1'b1, 4'h0);
    tot_cnt++; if (code !== 10'd512) $display("FAIL mix_none: got %0d want 512", code); else pass_cnt++;
  endtask

  task automatic test_linear();
    ch_en = 4'b0001;
    do_reset();
    step(1'b0, 4'b0010);
    tot_cnt++; if (hp_sel !== 12'd149) $display("FAIL lin_inc: got %0d want 149", hp_sel); else pass_cnt++;
    repeat (2) step(1'b0, 4'b0001);
    tot_cnt++; if (hp_sel !== 12'd129) $display("FAIL lin_dec2: got %0d want 129", hp_sel); else pass_cnt++;
    repeat (20) step(1'b0, 4'b0001);
    tot_cnt++; if (hp_sel !== 12'd6) $display("FAIL lin_floor: got %0d want 6", hp_sel); else pass_cnt++;
    repeat (400) step(1'b0, 4'b0010);
    tot_cnt++; if (hp_sel !== 12'd3051) $display("FAIL lin_ceil: got %0d want 3051", hp_sel); else pass_cnt++;
  endtask

  task automatic test_exp();
    ch_en = 4'b0001;
    do_reset();
    step(1'b0, 4'b0100);
    tot_cnt++; if (leds[0] !== 1'b1) $display("FAIL exp_led: got %b want 1", leds[0]); else pass_cnt++;
    step(1'b0, 4'b0001);
    tot_cnt++; if (hp_sel !== 12'd69) $display("FAIL exp_half: got %0d want 69", hp_sel); else pass_cnt++;
    step(1'b0, 4'b0010);
    tot_cnt++; if (hp_sel !== 12'd138) $display("FAIL exp_double: got %0d want 138", hp_sel); else pass_cnt++;
    step(1'b0, 4'b0011);
    tot_cnt++; if (hp_sel !== 12'd138) $display("FAIL both_adj: got %0d want 138", hp_sel); else pass_cnt++;
    repeat (5) step(1'b0, 4'b0001);
    tot_cnt++; if (hp_sel !== 12'd6) $display("FAIL exp_floor: got %0d want 6", hp_sel); else pass_cnt++;
    step(1'b0, 4'b0001);
    tot_cnt++; if (hp_sel !== 12'd6) $display("FAIL exp_floor_hold: got %0d want 6", hp_sel); else pass_cnt++;
    step(1'b0, 4'b0110);
    tot_cnt++; if (hp_sel !== 12'd12) $display("FAIL mode_old_used: got %0d want 12", hp_sel); else pass_cnt++;
    tot_cnt++; if (leds[0] !== 1'b0) $display("FAIL mode_back_lin: got %b want 0", leds[0]); else pass_cnt++;
    repeat (152) step(1'b0, 4'b0010);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0010);
    tot_cnt++; if (hp_sel !== 12'd3051) $display("FAIL exp_ceil: got %0d want 3051", hp_sel); else pass_cnt++;
  endtask

  task automatic test_sel();
    ch_en = 4'b0001;
    do_reset();
    repeat (3) step(1'b0, 4'b1000);
    tot_cnt++; if (leds[2:1] !== 2'b11) $display("FAIL sel3: got %b want 11", leds[2:1]); else pass_cnt++;
    tot_cnt++; if (leds[3] !== 1'b0) $display("FAIL sel3_en: got %b want 0", leds[3]); else pass_cnt++;
    step(1'b0, 4'b1000);
    tot_cnt++; if (leds[2:1] !== 2'b00) $display("FAIL sel_wrap: got %b want 00", leds[2:1]); else pass_cnt++;
    step(1'b0, 4'b1010);
    tot_cnt++; if (leds[2:1] !== 2'b01) $display("FAIL sel_adv: got %b want 01", leds[2:1]); else pass_cnt++;
    tot_cnt++; if (hp_sel !== 12'd139) $display("FAIL sel_ch1_hp: got %0d want 139", hp_sel); else pass_cnt++;
    repeat (3) step(1'b0, 4'b1000);
    tot_cnt++; if (hp_sel !== 12'd149) $display("FAIL sel_ch0_hp: got %0d want 149", hp_sel); else pass_cnt++;
  endtask

  task automatic test_period_shrink();
    ch_en = 4'b0001;
    do_reset();
    repeat (100) step(1'b1, 4'h0);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0001);
    tot_cnt++; if (hp_sel !== 12'd69) $display("FAIL shrink_hp: got %0d want 69", hp_sel); else pass_cnt++;
    step(1'b1, 4'h0);
    tot_cnt++; if (code !== 10'd612) $display("FAIL shrink_pre: got %0d want 612", code); else pass_cnt++;
    step(1'b1, 4'h0);
    tot_cnt++; if (code !== 10'd412) $display("FAIL shrink_toggle: got %0d want 412", code); else pass_cnt++;
    for (int k = 0; k < 150; k++) begin
      step(1'b1, (k % 40 == 7) ? 4'b0010 : 4'b0000);
      tot_cnt++;
      if (code !== 10'(m_code)) $display("FAIL shrink_run %0d: got %0d want %0d", k, code, m_code);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    ch_en = 4'b1111;
    do_reset();
    for (int k = 1; k <= 5000; k++) begin
      if (k == 4000) begin
        rst = 1'b0;
        step(1'b1, 4'b1111);
        rst = 1'b1;
        m_reset();
        tot_cnt++; if (code !== 10'd512) $display("FAIL rand_rst_code: got %0d want 512", code); else pass_cnt++;
        tot_cnt++; if (leds[2:0] !== 3'b000) $display("FAIL rand_rst_leds: got %b want 000", leds[2:0]); else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
          tot_cnt++;
          if (hp_sel !== 12'd139) $display("FAIL rand_rst_hp ch%0d: got %0d want 139", c, hp_sel); else pass_cnt++;
          step(1'b0, 4'b1000);
        end
        ch_en = 4'b1111;
        step(1'b1, 4'h0);
        tot_cnt++; if (code !== 10'd912) $display("FAIL rand_rst_high: got %0d want 912", code); else pass_cnt++;
      end
      ch_en = 4'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      step(1'b1, b);
      tot_cnt++;
      if (code !== 10'(m_code)) $display("FAIL rand_code %0d: got %0d want %0d", k, code, m_code); else pass_cnt++;
      tot_cnt++;
      if (code_big !== 10'(m_code_big)) $display("FAIL rand_code_big %0d: got %0d want %0d", k, code_big, m_code_big); else pass_cnt++;
      tot_cnt++;
      if (hp_sel !== 12'(m_hp[m_sel])) $display("FAIL rand_hp %0d: got %0d want %0d", k, hp_sel, m_hp[m_sel]); else pass_cnt++;
      tot_cnt++;
      if (leds !== m_leds()) $display("FAIL rand_leds %0d: got %b want %b", k, leds, m_leds()); else pass_cnt++;
      repeat ($urandom_range(1, 8)) begin
        b = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
        step(1'b0, b);
      end
    end
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    test_reset();
    test_single_channel();
    test_mix();
    test_linear();
    test_exp();
    test_sel();
    test_period_shrink();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/sq_wave_mixer.md
Name: sq_wave_mixer

Overview:
Parametrised successor to the single-channel square-wave generator. It runs NUM_CH independent square-wave channels, each with its own half-period, and mixes the enabled channels into one offset-binary DAC/PWM code. Samples advance on the existing next_sample pull handshake. Button pulses select a channel, adjust its period in linear or exponential mode, and toggle the adjustment mode.

Parameters:
NUM_CH, 4, number of square-wave channels (2..8)
CODE_W, 10, output code width
PERIOD_W, 12, half-period register width, in samples
CH_AMP, 100, per-channel contribution magnitude, in code LSBs
HP_DEFAULT, 139, reset half-period, in samples (about 440 Hz at 122 kHz sample rate)
HP_MIN, 6, minimum half-period (saturation floor)
HP_MAX, 3051, maximum half-period (saturation ceiling)
LIN_STEP, 10, linear-mode half-period step

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset; all state is initialised on any rising clk edge while rst=0
next_sample  in  1  single-cycle sample pull
buttons  in  4  single-cycle pulses, already debounced: [0] shorten period, [1] lengthen period, [2] toggle mode, [3] advance selected channel
ch_en  in  NUM_CH  per-channel enable; a disabled channel contributes 0
code  out  CODE_W  mixed sample, registered
leds  out  4  [0]=mode (1=exponential), [2:1]=sel[1:0], [3]=ch_en[sel]
hp_sel  out  PERIOD_W  half-period of the selected channel (observation port)

Behaviour:
- Reset values: code=2^(CODE_W-1) (MID, 512 by default); every hp=HP_DEFAULT; every cnt=0; every channel level=high; mode=linear; sel=0. This gives leds=4'b0000 except leds[3]=ch_en[0], and hp_sel=HP_DEFAULT.
- Sample handshake: on an edge where next_sample=1:
  - code <= clamp(MID + sum over enabled ch of (level ? +CH_AMP : -CH_AMP)), using the pre-edge levels;
  - each channel then advances.
  - The new code is valid the cycle after the pulse, and code holds between pulses.
- Mixing arithmetic: signed, width CODE_W+4. The result clamps to [0, 2^CODE_W-1].
- Channel advance: if cnt >= hp-1 then cnt<=0 and level toggles; else cnt<=cnt+1.
  - The >= comparison means lowering hp below the current cnt causes an immediate toggle on the next sample, never a counter wrap.
- Period adjust, applied to the channel selected before this edge:
  - Linear mode: hp ± LIN_STEP.
  - Exponential mode: buttons[0] gives hp>>1; buttons[1] gives hp<<1, computed at PERIOD_W+1 bits.
  - Results saturate to [HP_MIN, HP_MAX].
  - buttons[0] and buttons[1] asserted together: no change.
  - A period change does not reset cnt or level.
- buttons[2] toggles mode. An adjust in the same cycle uses the old mode.
- buttons[3]: sel <= (sel==NUM_CH-1) ? 0 : sel+1. An adjust in the same cycle targets the old sel.
- Every pulse counts; there is no internal debounce or rate limit.
- Buttons and next_sample in the same cycle: both take effect. The channel advance compares against the pre-edge hp.
- ch_en changes affect only the next computed sample; counters keep running while a channel is disabled.
- Reset asserted mid-operation: all state returns to reset values at that edge; next_sample and buttons are ignored while rst=0.

Decomposition:
- Shared package/header holds:
  - mode encoding (LINEAR=0, EXP=1);
  - button index constants (BTN_DEC=0, BTN_INC=1, BTN_MODE=2, BTN_SEL=3);
  - the MID derivation function.
- Sub-module sq_wave_channel: one channel's hp register, cnt, level, and saturating linear/exponential adjust logic. The top generates NUM_CH instances, plus the selection logic, mode register, mixer/clamp, and code register.

Test Plan:
- Reset, ch_en=4'b0001, first next_sample -> code=612. Samples 1..139 read 612; sample 140 reads 412; sample 279 reads 612 again.
- ch_en=4'b1111, reset, one pulse -> code=912. ch_en=0 -> code=512. Build with CH_AMP=200 and all channels high -> code clamps to 1023.
- Linear mode, sel=0:
  - buttons[1] -> hp_sel=149;
  - buttons[0] x2 -> 129;
  - 20 further buttons[0] pulses -> saturate at 6;
  - 400 buttons[1] pulses -> 3051.
- buttons[2] -> leds[0]=1:
  - from 139, buttons[0] -> 69, then buttons[1] -> 138;
  - from 3000, buttons[1] -> 3051;
  - from 6, buttons[0] -> 6.
- buttons[3] x3 -> leds[2:1]=2'b11; 4th pulse -> 2'b00. buttons[3]+buttons[1] in the same cycle from sel=0 -> channel 0 becomes 149, channel 1 stays 139.
- Random next_sample spacing of 2..9 cycles over 5000 samples:
  - with rst=0 for one edge at sample 4000 -> code=512;
  - afterwards all hp=139, mode=linear, sel=0;
  - the waveform period restarts from the high phase.
